mem_port_arbiter: RTL

- Shares the single unified data/instruction memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Grants one access per enabled cycle and drives the memory's address, offset address, write data, write enable and width controls.
- Tracks the memory's one-cycle synchronous read latency and returns read data tagged to the owning requester.
- Sits between the fetch/execute stages and the memory block. All state advances only on cycles where `clk_enable` is high.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch (IF) and
// load/store (LS), with LS priority bounded by a starvation limit.
module mem_port_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] DISPLAY_ADDR = 32'h7fe
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_sext,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_offset_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    output logic        mem_upper_half,
    output logic        mem_byte1,
    output logic        mem_upper_half_r,
    output logic        mem_byte1_r,
    output logic        mem_sext_r,
    output logic        mem_use_trunc,
    input  logic [31:0] mem_data_out,
    output logic [15:0] display_writes
);

    // Handshake: a requester holds req and its payload until it sees gnt in
    // the same enabled cycle; read data returns with rvalid on the next
    // enabled cycle. There is no queueing and no backpressure on responses.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [1:0] SIZE_WORD = 2'b10;

    owner_t      owner_q, owner_d;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [3:0]  starve_cnt, starve_d;
    logic [1:0]  req_size;
    logic        disp_hit;

    always_comb begin
        if_gnt = clk_enable & if_req & (~ls_req | (starve_cnt == LIMIT));
        ls_gnt = clk_enable & ls_req & ~if_gnt;
    end

    // Anything other than an LS grant presents the fetch side as a word read.
    always_comb begin
        mem_addr        = ls_gnt ? ls_addr : if_addr;
        mem_offset_addr = mem_addr + 32'd4;
        mem_data_in     = ls_gnt ? ls_wdata : 32'd0;
        mem_we          = ls_gnt & ls_we;
        req_size        = ls_gnt ? ls_size : SIZE_WORD;
        mem_upper_half  = clk_enable & req_size[1];
        mem_byte1       = clk_enable & (req_size[1] | req_size[0]);
    end

    always_comb begin
        starve_d = starve_cnt;
        if (if_gnt || !if_req) begin
            starve_d = 4'd0;
        end else if (ls_gnt && starve_cnt != LIMIT) begin
            starve_d = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt && !ls_we) begin
            owner_d = OWN_LS;
        end
    end

    assign disp_hit = ls_gnt & ls_we & (ls_addr == DISPLAY_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q        <= OWN_NONE;
            size_q         <= 2'b00;
            sext_q         <= 1'b0;
            starve_cnt     <= 4'd0;
            display_writes <= 16'd0;
        end else if (clk_enable) begin
            owner_q    <= owner_d;
            size_q     <= req_size;
            sext_q     <= ls_gnt & ls_sext;
            starve_cnt <= starve_d;
            if (disp_hit && display_writes != 16'hffff) begin
                display_writes <= display_writes + 16'd1;
            end
        end
    end

    always_comb begin
        mem_upper_half_r = size_q[1];
        mem_byte1_r      = size_q[1] | size_q[0];
        mem_sext_r       = sext_q;
        mem_use_trunc    = (owner_q == OWN_LS);
        if_rvalid        = clk_enable & (owner_q == OWN_IF);
        ls_rvalid        = clk_enable & (owner_q == OWN_LS);
        if_rdata         = (owner_q == OWN_IF) ? mem_data_out : 32'd0;
        ls_rdata         = (owner_q == OWN_LS) ? mem_data_out : 32'd0;
    end

endmodule
